// File: rtl/motion_pkg.sv
// Shared widths, bounding-box record and merge helper for the motion detector.
package motion_pkg;

   localparam int unsigned H_WIDTH   = 11;
   localparam int unsigned V_WIDTH   = 10;
   localparam int unsigned PIX_WIDTH = 8;
   localparam int unsigned CNT_WIDTH = H_WIDTH + V_WIDTH;

   typedef logic [H_WIDTH-1:0]   hcoord_t;
   typedef logic [V_WIDTH-1:0]   vcoord_t;
   typedef logic [PIX_WIDTH-1:0] pix_t;
   typedef logic [CNT_WIDTH-1:0] cnt_t;

   typedef struct packed {
      hcoord_t x_min;
      hcoord_t x_max;
      vcoord_t y_min;
      vcoord_t y_max;
      cnt_t    count;
   } bbox_t;

   // Min fields start at all-ones so the first motion pixel always wins.
   localparam bbox_t BBOX_EMPTY = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0, count: '0};

   function automatic bbox_t bbox_add(input bbox_t b, input hcoord_t x, input vcoord_t y);
      bbox_t r;
      r = b;
      if (x < r.x_min) r.x_min = x;
      if (x > r.x_max) r.x_max = x;
      if (y < r.y_min) r.y_min = y;
      if (y > r.y_max) r.y_max = y;
      if (r.count != '1) r.count = r.count + CNT_WIDTH'(1);
      return r;
   endfunction

endpackage

// File: rtl/motion_detect_if.sv
// Pixel-in / mask-and-frame-results-out bundle of the motion detector.
interface motion_detect_if;
   import motion_pkg::*;

   logic    valid_in;
   hcoord_t hcount_in;
   vcoord_t vcount_in;
   pix_t    pixel_in;
   pix_t    prev_pixel_in;
   pix_t    threshold_in;

   logic    valid_out;
   logic    motion_out;
   hcoord_t hcount_out;
   vcoord_t vcount_out;
   logic    frame_done_out;
   logic    detected_out;
   hcoord_t x_min_out;
   hcoord_t x_max_out;
   vcoord_t y_min_out;
   vcoord_t y_max_out;
   cnt_t    count_out;

   modport master (
      output valid_in, hcount_in, vcount_in, pixel_in, prev_pixel_in, threshold_in,
      input  valid_out, motion_out, hcount_out, vcount_out, frame_done_out, detected_out,
      input  x_min_out, x_max_out, y_min_out, y_max_out, count_out
   );

   modport slave (
      input  valid_in, hcount_in, vcount_in, pixel_in, prev_pixel_in, threshold_in,
      output valid_out, motion_out, hcount_out, vcount_out, frame_done_out, detected_out,
      output x_min_out, x_max_out, y_min_out, y_max_out, count_out
   );

endinterface

// File: rtl/bbox_accumulator.sv
// Per-frame motion bounding box / count accumulator with frame-end result latch.
module bbox_accumulator
   import motion_pkg::*;
#(
   parameter int unsigned MIN_COUNT = 16
) (
   input  logic    clk_in,
   input  logic    rst_in,
   input  logic    valid_in,
   input  logic    motion_in,
   input  hcoord_t x_in,
   input  vcoord_t y_in,
   input  logic    frame_end_in,
   output bbox_t   bbox_out,
   output logic    detected_out,
   output logic    done_out
);

   localparam cnt_t MIN_CNT = CNT_WIDTH'(MIN_COUNT);

   bbox_t r_acc;
   bbox_t r_result;
   logic  r_detected;
   logic  r_done;
   bbox_t w_merged;

   // The final pixel of a frame must land in that frame's result, not the next.
   always_comb begin
      w_merged = r_acc;
      if (valid_in && motion_in) w_merged = bbox_add(r_acc, x_in, y_in);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_acc      <= BBOX_EMPTY;
         r_result   <= '0;
         r_detected <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= frame_end_in;
         if (frame_end_in) begin
            r_acc <= BBOX_EMPTY;
            if (w_merged.count == '0) begin
               r_result   <= '0;
               r_detected <= 1'b0;
            end else begin
               r_result   <= w_merged;
               r_detected <= (w_merged.count >= MIN_CNT);
            end
         end else begin
            r_acc <= w_merged;
         end
      end
   end

   assign bbox_out     = r_result;
   assign detected_out = r_detected;
   assign done_out     = r_done;

endmodule

// File: rtl/motion_detect.sv
// Frame-difference motion detector: two-stage pixel pipeline plus per-frame bbox results.
module motion_detect
   import motion_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = 1280,
   parameter int unsigned V_ACTIVE  = 720,
   parameter int unsigned MIN_COUNT = 16
) (
   input logic            clk_in,
   input logic            rst_in,
   motion_detect_if.slave bus
);

   localparam hcoord_t H_LAST = hcoord_t'(H_ACTIVE - 1);
   localparam vcoord_t V_LAST = vcoord_t'(V_ACTIVE - 1);

   logic    w_active;
   pix_t    w_diff;
   logic    w_frame_end;
   bbox_t   w_bbox;
   logic    w_detected;
   logic    w_done;

   logic    r_s1_valid;
   pix_t    r_s1_diff;
   pix_t    r_s1_thr;
   hcoord_t r_s1_h;
   vcoord_t r_s1_v;

   logic    r_s2_valid;
   logic    r_s2_motion;
   hcoord_t r_s2_h;
   vcoord_t r_s2_v;

   always_comb begin
      w_active = bus.valid_in && (bus.hcount_in <= H_LAST) && (bus.vcount_in <= V_LAST);
      w_diff   = (bus.pixel_in >= bus.prev_pixel_in) ? bus.pixel_in - bus.prev_pixel_in
                                                     : bus.prev_pixel_in - bus.pixel_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_s1_valid  <= 1'b0;
         r_s1_diff   <= '0;
         r_s1_thr    <= '0;
         r_s1_h      <= '0;
         r_s1_v      <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_motion <= 1'b0;
         r_s2_h      <= '0;
         r_s2_v      <= '0;
      end else begin
         r_s1_valid  <= w_active;
         r_s1_diff   <= w_diff;
         r_s1_thr    <= bus.threshold_in;
         r_s1_h      <= bus.hcount_in;
         r_s1_v      <= bus.vcount_in;
         r_s2_valid  <= r_s1_valid;
         r_s2_motion <= r_s1_valid && (r_s1_diff > r_s1_thr);
         r_s2_h      <= r_s1_h;
         r_s2_v      <= r_s1_v;
      end
   end

   assign w_frame_end = r_s2_valid && (r_s2_h == H_LAST) && (r_s2_v == V_LAST);

   bbox_accumulator #(
      .MIN_COUNT (MIN_COUNT)
   ) u_bbox (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .valid_in     (r_s2_valid),
      .motion_in    (r_s2_motion),
      .x_in         (r_s2_h),
      .y_in         (r_s2_v),
      .frame_end_in (w_frame_end),
      .bbox_out     (w_bbox),
      .detected_out (w_detected),
      .done_out     (w_done)
   );

   assign bus.valid_out      = r_s2_valid;
   assign bus.motion_out     = r_s2_motion;
   assign bus.hcount_out     = r_s2_h;
   assign bus.vcount_out     = r_s2_v;
   assign bus.frame_done_out = w_done;
   assign bus.detected_out   = w_detected;
   assign bus.x_min_out      = w_bbox.x_min;
   assign bus.x_max_out      = w_bbox.x_max;
   assign bus.y_min_out      = w_bbox.y_min;
   assign bus.y_max_out      = w_bbox.y_max;
   assign bus.count_out      = w_bbox.count;

endmodule

// File: tb/tb_motion_detect.sv
// Scoreboard bench for motion_detect: directed pixels, queued expectations, negedge monitor.
module tb_motion_detect;
   import motion_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   motion_detect_if bus ();

   motion_detect #(
      .H_ACTIVE  (1280),
      .V_ACTIVE  (720),
      .MIN_COUNT (2)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   typedef struct {
      hcoord_t h;
      vcoord_t v;
      logic    m;
      int      due;
   } mask_exp_t;

   typedef struct {
      int   xmin, xmax, ymin, ymax, cnt;
      logic det;
      int   due;
   } frame_exp_t;

   mask_exp_t  mq[$];
   frame_exp_t fq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a mask pixel or a frame result.
   mask_exp_t  me;
   frame_exp_t fe;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.valid_out) begin
            if (mq.size() == 0) begin
               chk("unexpected valid_out", 32'd1, 32'd0);
            end else begin
               me = mq.pop_front();
               chk("mask latency", cyc, me.due);
               chk("motion_out", 32'(bus.motion_out), 32'(me.m));
               chk("hcount_out", 32'(bus.hcount_out), 32'(me.h));
               chk("vcount_out", 32'(bus.vcount_out), 32'(me.v));
            end
         end else begin
            chk("bubble motion_out", 32'(bus.motion_out), 32'd0);
         end
         if (bus.frame_done_out) begin
            if (fq.size() == 0) begin
               chk("unexpected frame_done_out", 32'd1, 32'd0);
            end else begin
               fe = fq.pop_front();
               chk("frame latency", cyc, fe.due);
               chk("x_min_out", 32'(bus.x_min_out), fe.xmin);
               chk("x_max_out", 32'(bus.x_max_out), fe.xmax);
               chk("y_min_out", 32'(bus.y_min_out), fe.ymin);
               chk("y_max_out", 32'(bus.y_max_out), fe.ymax);
               chk("count_out", 32'(bus.count_out), fe.cnt);
               chk("detected_out", 32'(bus.detected_out), 32'(fe.det));
            end
         end
      end
   end

   task automatic px(input logic vld, input int h, input int v, input int p, input int pp,
                     input int thr, input logic exp_act, input logic exp_m);
      mask_exp_t e;
      bus.valid_in      = vld;
      bus.hcount_in     = hcoord_t'(h);
      bus.vcount_in     = vcoord_t'(v);
      bus.pixel_in      = pix_t'(p);
      bus.prev_pixel_in = pix_t'(pp);
      bus.threshold_in  = pix_t'(thr);
      if (exp_act) begin
         e.h   = hcoord_t'(h);
         e.v   = vcoord_t'(v);
         e.m   = exp_m;
         e.due = cyc + 2;
         mq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Drives the (1279,719) pixel and queues the frame result expected 3 cycles later.
   task automatic frame_end(input logic m, input int p, input int pp, input int thr,
                            input int xmin, input int xmax, input int ymin, input int ymax,
                            input int cnt, input logic det);
      frame_exp_t f;
      f.xmin = xmin; f.xmax = xmax; f.ymin = ymin; f.ymax = ymax;
      f.cnt  = cnt;  f.det  = det;  f.due  = cyc + 3;
      fq.push_back(f);
      px(1'b1, 1279, 719, p, pp, thr, 1'b1, m);
   endtask

   task automatic idle(input int n);
      bus.valid_in = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
      mq.delete();
      fq.delete();
      chk("rst valid_out", 32'(bus.valid_out), 32'd0);
      chk("rst motion_out", 32'(bus.motion_out), 32'd0);
      chk("rst frame_done_out", 32'(bus.frame_done_out), 32'd0);
      chk("rst detected_out", 32'(bus.detected_out), 32'd0);
      chk("rst count_out", 32'(bus.count_out), 32'd0);
      chk("rst x_max_out", 32'(bus.x_max_out), 32'd0);
      chk("rst y_max_out", 32'(bus.y_max_out), 32'd0);
      chk("rst x_min_out", 32'(bus.x_min_out), 32'd0);
      chk("rst y_min_out", 32'(bus.y_min_out), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      bus.valid_in      = 1'b0;
      bus.hcount_in     = '0;
      bus.vcount_in     = '0;
      bus.pixel_in      = '0;
      bus.prev_pixel_in = '0;
      bus.threshold_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Strict threshold compare, pixel=100 thr=10
      px(1'b1, 1, 0, 100, 89, 10, 1'b1, 1'b1);
      px(1'b1, 2, 0, 100, 90, 10, 1'b1, 1'b0);
      px(1'b1, 3, 0, 100, 111, 10, 1'b1, 1'b1);
      idle(4);
      do_reset();

      // Frame A: motion at (10,5) and (300,700) only
      px(1'b1, 10, 5, 100, 80, 10, 1'b1, 1'b1);
      px(1'b1, 500, 500, 60, 70, 10, 1'b1, 1'b0);
      px(1'b1, 600, 200, 60, 70, 11, 1'b1, 1'b0);
      px(1'b1, 300, 700, 0, 255, 254, 1'b1, 1'b1);
      px(1'b1, 301, 700, 255, 0, 255, 1'b1, 1'b0);
      frame_end(1'b0, 50, 50, 0, 10, 300, 5, 700, 2, 1'b1);

      // All-static frame
      px(1'b1, 0, 0, 77, 77, 0, 1'b1, 1'b0);
      px(1'b1, 1279, 0, 10, 10, 5, 1'b1, 1'b0);
      px(1'b1, 640, 360, 200, 195, 5, 1'b1, 1'b0);
      frame_end(1'b0, 9, 9, 0, 0, 0, 0, 0, 0, 1'b0);

      // Final pixel is the only motion; next frame starts the very next cycle
      frame_end(1'b1, 200, 0, 50, 1279, 1279, 719, 719, 1, 1'b0);
      px(1'b1, 0, 0, 0, 30, 20, 1'b1, 1'b1);
      px(1'b1, 5, 3, 30, 0, 20, 1'b1, 1'b1);
      frame_end(1'b0, 1, 1, 0, 0, 5, 0, 3, 2, 1'b1);

      // Blanking and toggling valid with large diffs must not count
      px(1'b1, 20, 20, 0, 100, 10, 1'b1, 1'b1);
      px(1'b0, 21, 20, 0, 200, 10, 1'b0, 1'b0);
      px(1'b1, 1280, 20, 0, 200, 10, 1'b0, 1'b0);
      px(1'b0, 30, 25, 0, 200, 10, 1'b0, 1'b0);
      px(1'b1, 40, 30, 200, 0, 10, 1'b1, 1'b1);
      px(1'b0, 1279, 719, 0, 200, 10, 1'b0, 1'b0);
      px(1'b1, 1290, 719, 0, 200, 10, 1'b0, 1'b0);
      px(1'b0, 5, 5, 0, 200, 10, 1'b0, 1'b0);
      px(1'b1, 50, 720, 0, 200, 10, 1'b0, 1'b0);
      frame_end(1'b0, 3, 3, 0, 20, 40, 20, 30, 2, 1'b1);
      idle(4);

      // Reset in the middle of a frame discards its 50 motion pixels
      for (int i = 0; i < 50; i++) px(1'b1, i, 100, 50, 45, 0, 1'b1, 1'b1);
      do_reset();
      idle(3);
      px(1'b1, 7, 8, 0, 9, 8, 1'b1, 1'b1);
      frame_end(1'b0, 4, 4, 0, 7, 7, 8, 8, 1, 1'b0);

      idle(8);
      chk("mask queue drained", 32'(mq.size()), 32'd0);
      chk("frame queue drained", 32'(fq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/motion_detect.md
# motion_detect

Frame-difference motion detector for the motiongate video path. Consumes the live luma stream plus the co-located previous-frame luma from the frame buffer, and emits a per-pixel motion mask with its coordinates, 2 cycles behind the input. Also emits a once-per-frame bounding box, a motion pixel count and a detected flag. The overlay stage downstream aligns its own pixel stream to the mask with a 2-deep delay line.

## Interface
- H_WIDTH, 11, hcount width
- V_WIDTH, 10, vcount width
- PIX_WIDTH, 8, luma width
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- MIN_COUNT, 16, minimum motion pixels per frame for `detected_out`
- clk_in  input  1  pixel clock; single clock domain
- rst_in  input  1  synchronous, active-high reset
- valid_in  input  1  pixel qualifier
- hcount_in  input  H_WIDTH  pixel x
- vcount_in  input  V_WIDTH  pixel y
- pixel_in  input  PIX_WIDTH  current-frame luma
- prev_pixel_in  input  PIX_WIDTH  previous-frame luma, same coordinate, same cycle
- threshold_in  input  PIX_WIDTH  motion threshold; sampled with each pixel
- valid_out  output  1  mask qualifier
- motion_out  output  1  1 = pixel differs by more than the threshold
- hcount_out  output  H_WIDTH  x aligned to `motion_out`
- vcount_out  output  V_WIDTH  y aligned to `motion_out`
- frame_done_out  output  1  one-cycle pulse; frame results are valid
- detected_out  output  1  frame motion count ≥ MIN_COUNT
- x_min_out, x_max_out  output  H_WIDTH  bounding box x
- y_min_out, y_max_out  output  V_WIDTH  bounding box y
- count_out  output  H_WIDTH+V_WIDTH  motion pixels in the frame; saturating

## Operation
- Stage 1 registers:
  - diff = |pixel_in − prev_pixel_in|, unsigned, PIX_WIDTH bits, no overflow.
  - threshold_in, valid, hcount and vcount.
  - A pixel is active when valid_in=1, hcount_in < H_ACTIVE and vcount_in < V_ACTIVE. Inactive pixels carry valid=0.
- Stage 2 registers:
  - motion = valid & (diff > threshold). Strict compare: diff == threshold gives 0.
  - valid, hcount and vcount are forwarded unchanged.
- The pipeline never stalls. Bubbles (valid=0) advance normally, and their `motion_out` is forced to 0.
- Accumulators (internal) update on every stage-2 motion pixel:
  - cnt += 1, saturating at all-ones.
  - xmin/xmax/ymin/ymax take the min/max of the coordinates.
  - Empty state: cnt=0, xmin/ymin = all-ones, xmax/ymax = 0.
- Frame end is a stage-2 valid pixel at (H_ACTIVE−1, V_ACTIVE−1). On that cycle:
  - Result registers load the accumulator values merged with that final pixel's contribution.
  - Accumulators return to the empty state.
  - On the next clock, `frame_done_out`=1 for exactly one cycle.
- Result registers hold until the next frame end.
  - If cnt=0: all bbox outputs 0 and `detected_out`=0.
  - Otherwise `detected_out` = (cnt ≥ MIN_COUNT).
- A frame with no final pixel (truncated stream) produces no `frame_done_out`. Its accumulation continues into the next frame.

## Timing
- Mask latency: 2 cycles from input to `valid_out`/`motion_out`/`hcount_out`/`vcount_out`.
- Frame latency: final pixel at the input at cycle N gives results and `frame_done_out` at N+3.
- Reset values:
  - Every output is 0.
  - Pipeline valid bits are 0.
  - Accumulators are in the empty state.
- Reset mid-frame: the partial frame is discarded, and no `frame_done_out` is issued for it.
- Back-to-back frames: the first pixel of the next frame may arrive the cycle after the final pixel. It accumulates into the fresh empty state and is not lost.
- `threshold_in` may change on any cycle. Each pixel uses the value sampled alongside it.

## Structure
- Package `motion_pkg` holds:
  - width localparams derived from H_WIDTH/V_WIDTH;
  - a `bbox_t` struct (x_min, x_max, y_min, y_max, count);
  - the `BBOX_EMPTY` constant.
- Sub-module `bbox_accumulator` holds the min/max/count registers, the saturation logic and the frame-end latch. It takes (valid, motion, x, y, frame_end) and outputs `bbox_t` plus done.
- Top level keeps the two pixel stages and the active-region qualification.

## Test plan
- Threshold test (pixel=100, threshold=10): prev=89 → `motion_out`=1; prev=90 → `motion_out`=0; prev=111 → `motion_out`=1. Each appears exactly 2 cycles after its input.
- Frame with motion only at (10,5) and (300,700), MIN_COUNT=2 → at N+3: bbox x 10..300, y 5..700, count 2, `detected_out`=1, one-cycle pulse.
- All-static frame → count 0, bbox all 0, `detected_out`=0, `frame_done_out` still pulses.
- Final pixel (1279,719) is the only motion pixel, and the next frame starts the following cycle with motion at (0,0) → frame 1 reports bbox 1279/1279/719/719 count 1; frame 2 bbox starts at (0,0).
- `valid_in` toggling every cycle, plus pixels at hcount=1280 with large diffs → blanking pixels give `motion_out`=0 and are excluded from bbox.
- `rst_in` pulsed mid-frame after 50 motion pixels → all outputs 0 next cycle, no done pulse. Next full frame reports only its own pixels.
